// File: rtl/firc_mac_sched.sv
`default_nettype none
// ============================================================================
//  Module   : firc_mac_sched
//  Purpose  : Cycle scheduler for the complex symmetric FIR (29 taps,
//             15 stored complex coefficients, 5 shared complex multipliers).
//             Pops one sample from the FIFO, walks the multiplier operand
//             muxes through NPHASE phases, and issues accumulator
//             load/add/finish strobes plus the output push, delayed to line
//             up with the PIPE-cycle multiplier pipeline.
//  Ports    : Clk, Reset      - clock, synchronous active-high reset
//             Empty           - sample FIFO empty
//             PushCoef        - coefficient write this cycle (defers starts)
//             PullOut         - pop FIFO / shift sample delay line this edge
//             Phase,PhaseValid- operand mux select and its qualifier
//             AccEn,AccFirst,AccLast - accumulator strobes at product arrival
//             PushOut,Tainted - result valid pulse and coefficient-overlap flag
//             Busy            - scheduler or pipeline has work in flight
//  Revision : 1.0  initial release
// ============================================================================
module firc_mac_sched #(
  parameter int NPHASE = 3,   // mux phases per sample, 2..4
  parameter int PIPE   = 4    // mux select to product-valid latency, 1..8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Empty,
  input  logic       PushCoef,
  output logic       PullOut,
  output logic [1:0] Phase,
  output logic       PhaseValid,
  output logic       AccEn,
  output logic       AccFirst,
  output logic       AccLast,
  output logic       PushOut,
  output logic       Tainted,
  output logic       Busy
);

  localparam logic [1:0] c_last_phase = 2'(NPHASE - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One delay-pipe slot: tags travelling alongside a product.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic taint;
  } slot_t;

  state_t     r_state;
  logic [1:0] r_p;
  logic       r_taint;
  slot_t      r_slot [PIPE];
  logic       r_push_out;
  logic       r_tainted;

  logic       w_start;
  logic       w_run;
  logic       w_last;
  logic       w_taint_in;
  slot_t      w_slot_in;
  logic       w_any_slot;

  assign w_start = !Empty && !PushCoef;
  assign w_run   = (r_state == ST_RUN);
  assign w_last  = (r_p == c_last_phase);

  // Taint restarts at phase 0, so the value fed with phase 0 only reflects
  // a coefficient write in that very cycle.
  assign w_taint_in = ((r_p == 2'd0) ? 1'b0 : r_taint) | PushCoef;

  // A new sample may enter from IDLE or overlap the final phase of the
  // current one; reset suppresses the pop so no sample is lost.
  assign PullOut = !Reset && w_start && (!w_run || w_last);

  // --------------------------------------------------------------------------
  // Phase sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_p     <= 2'd0;
      r_taint <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_RUN;
            r_p     <= 2'd0;
          end
        end
        ST_RUN: begin
          r_taint <= w_taint_in;
          if (!w_last) begin
            r_p <= r_p + 2'd1;
          end else if (w_start) begin
            r_p <= 2'd0;
          end else begin
            // r_p keeps its last value so Phase holds while idle.
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Phase      = r_p;
  assign PhaseValid = w_run;

  // --------------------------------------------------------------------------
  // Tag delay pipe matching the multiplier latency
  // --------------------------------------------------------------------------
  always_comb begin
    w_slot_in       = '0;
    w_slot_in.valid = w_run;
    w_slot_in.first = w_run && (r_p == 2'd0);
    w_slot_in.last  = w_run && w_last;
    w_slot_in.taint = w_run && w_taint_in;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < PIPE; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_slot[0] <= w_slot_in;
      for (int i = 1; i < PIPE; i++) begin
        r_slot[i] <= r_slot[i-1];
      end
    end
  end

  assign AccEn    = r_slot[PIPE-1].valid;
  assign AccFirst = r_slot[PIPE-1].first;
  assign AccLast  = r_slot[PIPE-1].last;

  // --------------------------------------------------------------------------
  // Output push, one cycle after the last product is accumulated
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_push_out <= 1'b0;
      r_tainted  <= 1'b0;
    end else begin
      r_push_out <= r_slot[PIPE-1].valid && r_slot[PIPE-1].last;
      r_tainted  <= r_slot[PIPE-1].valid && r_slot[PIPE-1].last &&
                    r_slot[PIPE-1].taint;
    end
  end

  assign PushOut = r_push_out;
  assign Tainted = r_tainted;

  always_comb begin
    w_any_slot = 1'b0;
    for (int i = 0; i < PIPE; i++) begin
      w_any_slot = w_any_slot | r_slot[i].valid;
    end
  end

  // The push register is included so Busy covers the PushOut cycle itself.
  assign Busy = w_run || w_any_slot || r_push_out;

endmodule
`default_nettype wire

// File: tb/tb_firc_mac_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_firc_mac_sched
//  Purpose  : Self-checking bench for firc_mac_sched. Two instances
//             (NPHASE=3/PIPE=4 and NPHASE=2/PIPE=1) share the same Empty,
//             PushCoef and Reset stimulus; each is compared every cycle
//             against a sample-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_firc_mac_sched;

  localparam int N0   = 3;
  localparam int P0   = 4;
  localparam int N1   = 2;
  localparam int P1   = 1;
  localparam int MAXC = 1024;

  typedef struct packed {
    logic       pull;
    logic       pv;
    logic [1:0] ph;
    logic       ae;
    logic       af;
    logic       al;
    logic       po;
    logic       tn;
    logic       busy;
  } outs_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Empty = 1'b1;
  logic       PushCoef = 1'b0;

  logic       pull [2];
  logic       pv   [2];
  logic [1:0] ph   [2];
  logic       ae   [2];
  logic       af   [2];
  logic       al   [2];
  logic       po   [2];
  logic       tn   [2];
  logic       busy [2];

  int         tests = 0;
  int         fails = 0;
  int         t = 0;
  int         last_rst = -1;
  bit         popped  [2][MAXC];
  bit         pc_hist [MAXC];
  logic [1:0] last_phase [2];
  int         n_pull [2];
  int         n_push [2];

  always #5 Clk = ~Clk;

  firc_mac_sched #(.NPHASE(N0), .PIPE(P0)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .Empty(Empty), .PushCoef(PushCoef),
    .PullOut(pull[0]), .Phase(ph[0]), .PhaseValid(pv[0]),
    .AccEn(ae[0]), .AccFirst(af[0]), .AccLast(al[0]),
    .PushOut(po[0]), .Tainted(tn[0]), .Busy(busy[0])
  );

  firc_mac_sched #(.NPHASE(N1), .PIPE(P1)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Empty(Empty), .PushCoef(PushCoef),
    .PullOut(pull[1]), .Phase(ph[1]), .PhaseValid(pv[1]),
    .AccEn(ae[1]), .AccFirst(af[1]), .AccLast(al[1]),
    .PushOut(po[1]), .Tainted(tn[1]), .Busy(busy[1])
  );

  // A sample popped at cycle c runs phases in cycles c+1..c+n, reaches the
  // accumulator in c+1+p..c+n+p, and is pushed at c+n+p+1.
  function automatic logic taint_of(input int c, input int n);
    logic r = 1'b0;
    for (int k = c + 1; k <= c + n; k++) r = r | pc_hist[k];
    return r;
  endfunction

  function automatic outs_t expect_at(input int d, input logic e,
                                      input logic pc, input logic rs);
    int    n  = (d == 0) ? N0 : N1;
    int    p  = (d == 0) ? P0 : P1;
    outs_t o  = '0;
    bit    ok = 1'b1;
    o.ph = last_phase[d];
    for (int c = t - (n + p + 1); c < t; c++) begin
      if (c >= 0 && c > last_rst && popped[d][c]) begin
        if (t < c + n) ok = 1'b0;
        if (t >= c + 1 && t <= c + n) begin
          o.pv = 1'b1;
          o.ph = 2'(t - c - 1);
        end
        if (t >= c + 1 + p && t <= c + n + p) begin
          o.ae = 1'b1;
          o.af = (t == c + 1 + p);
          o.al = (t == c + n + p);
        end
        if (t == c + n + p + 1) begin
          o.po = 1'b1;
          o.tn = taint_of(c, n);
        end
        o.busy = 1'b1;
      end
    end
    o.pull = !rs && !e && !pc && ok;
    return o;
  endfunction

  task automatic check(input int d, input string tag,
                       input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL dut%0d %s cycle %0d: observed %0d expected %0d",
             d, tag, t, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare at the falling edge, advance.
  task automatic cycle(input logic e, input logic pc, input logic rs,
                       input bit chk);
    outs_t ex;
    outs_t ob;
    Empty      = e;
    PushCoef   = pc;
    Reset      = rs;
    pc_hist[t] = pc;
    @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      ex = expect_at(d, e, pc, rs);
      ob = {pull[d], pv[d], ph[d], ae[d], af[d], al[d], po[d], tn[d], busy[d]};
      if (chk) begin
        check(d, "PullOut",    {1'b0, ob.pull}, {1'b0, ex.pull});
        check(d, "PhaseValid", {1'b0, ob.pv},   {1'b0, ex.pv});
        check(d, "Phase",      ob.ph,           ex.ph);
        check(d, "AccEn",      {1'b0, ob.ae},   {1'b0, ex.ae});
        check(d, "AccFirst",   {1'b0, ob.af},   {1'b0, ex.af});
        check(d, "AccLast",    {1'b0, ob.al},   {1'b0, ex.al});
        check(d, "PushOut",    {1'b0, ob.po},   {1'b0, ex.po});
        check(d, "Tainted",    {1'b0, ob.tn},   {1'b0, ex.tn});
        check(d, "Busy",       {1'b0, ob.busy}, {1'b0, ex.busy});
      end
      n_pull[d] += int'(ob.pull);
      n_push[d] += int'(ob.po);
      if (ex.pv) last_phase[d] = ex.ph;
      popped[d][t] = ex.pull;
    end
    if (rs) begin
      last_rst      = t;
      last_phase[0] = 2'd0;
      last_phase[1] = 2'd0;
    end
    @(posedge Clk);
    #1;
    t++;
  endtask

  initial begin
    last_phase[0] = 2'd0;
    last_phase[1] = 2'd0;
    @(posedge Clk);
    #1;

    // Reset: first cycle has unknown state, afterwards everything is zero.
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1);

    // Single sample.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (12) cycle(1'b1, 1'b0, 1'b0, 1'b1);

    // Continuous stream (six samples on the default instance).
    repeat (16) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (14) cycle(1'b1, 1'b0, 1'b0, 1'b1);

    // Coefficient write overlapping the first sample, deferring the second.
    for (int i = 0; i < 6; i++) cycle(1'b0, (i >= 2 && i <= 4), 1'b0, 1'b1);
    repeat (14) cycle(1'b1, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a stream, then restart.
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (14) cycle(1'b1, 1'b0, 1'b0, 1'b1);

    // Empty toggling with one-cycle gaps.
    for (int i = 0; i < 20; i++) cycle(1'(i % 2), 1'b0, 1'b0, 1'b1);
    repeat (14) cycle(1'b1, 1'b0, 1'b0, 1'b1);

    // Random Empty / PushCoef; every pop must come back as one push.
    n_pull[0] = 0; n_pull[1] = 0;
    n_push[0] = 0; n_push[1] = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
            1'b0, 1'b1);
    end
    repeat (14) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      tests++;
      assert (n_push[d] === n_pull[d]) else begin
        fails++;
        $error("FAIL dut%0d push_count: observed %0d expected %0d",
               d, n_push[d], n_pull[d]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
